// File: rtl/comanda_afisaj.sv
// comanda_afisaj: control stage in front of the four-digit 7-segment display multiplexer.
// It synchronizes the three line-follower sensors and classifies the manoeuvre with a
// small state machine. From that it drives the blinking turn indications, the latched
// stop flag and a saturating two-digit BCD elapsed-seconds count.
module comanda_afisaj #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 12_500_000,
    parameter int STOP_HOLD = 1_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       senzor_stanga,
    input  logic       senzor_centru,
    input  logic       senzor_dreapta,
    output logic       semnal_stanga,
    output logic       semnal_dreapta,
    output logic       stop,
    output logic [3:0] cifra_zeci,
    output logic [3:0] cifra_unitati
);

    localparam int TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int HOLD_W  = (STOP_HOLD > 1) ? $clog2(STOP_HOLD) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(STOP_HOLD - 1);

    typedef enum logic [1:0] {
        MERGE    = 2'd0,
        VIRAJ_ST = 2'd1,
        VIRAJ_DR = 2'd2,
        OPRIT    = 2'd3
    } stare_t;

    logic [2:0]         sync1_r;
    logic [2:0]         sync2_r;
    stare_t             stare_r;
    stare_t             stare_s;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic [HOLD_W-1:0]  hold_cnt_s;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic [BLINK_W-1:0] blink_cnt_s;
    logic               faza_r;
    logic               faza_s;
    logic               restart_s;
    logic [TICK_W-1:0]  presc_r;
    logic [TICK_W-1:0]  presc_s;
    logic               tick_s;
    logic [3:0]         zeci_s;
    logic [3:0]         unitati_s;

    // Two-flop synchronizer for the asynchronous sensor triplet {L,C,R}.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= {senzor_stanga, senzor_centru, senzor_dreapta};
            sync2_r <= sync1_r;
        end
    end

    // Manoeuvre classification and stop-marker debounce; OPRIT only leaves on reset.
    always_comb begin
        stare_s    = stare_r;
        hold_cnt_s = {HOLD_W{1'b0}};
        case (stare_r)
            OPRIT: begin
                stare_s    = OPRIT;
                hold_cnt_s = hold_cnt_r;
            end
            default: begin
                case (sync2_r)
                    3'b100, 3'b110: stare_s = VIRAJ_ST;
                    3'b001, 3'b011: stare_s = VIRAJ_DR;
                    3'b010:         stare_s = MERGE;
                    3'b111: begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            stare_s    = OPRIT;
                            hold_cnt_s = hold_cnt_r;
                        end else begin
                            hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                        end
                    end
                    default: stare_s = stare_r;  // line lost or invalid pattern: hold
                endcase
            end
        endcase
    end

    // Blink phase: restarts ON at counter 0 when a turn state is entered, otherwise free-runs.
    always_comb begin
        restart_s = (stare_s != stare_r) && ((stare_s == VIRAJ_ST) || (stare_s == VIRAJ_DR));
        if (restart_s) begin
            blink_cnt_s = {BLINK_W{1'b0}};
            faza_s      = 1'b1;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_s = {BLINK_W{1'b0}};
            faza_s      = ~faza_r;
        end else begin
            blink_cnt_s = blink_cnt_r + BLINK_W'(1);
            faza_s      = faza_r;
        end
    end

    // Seconds prescaler and saturating BCD count; both freeze once the car has stopped.
    always_comb begin
        presc_s   = presc_r;
        tick_s    = 1'b0;
        zeci_s    = cifra_zeci;
        unitati_s = cifra_unitati;
        if (stare_r == OPRIT) begin
            presc_s = presc_r;
        end else if (presc_r == TICK_LAST) begin
            presc_s = {TICK_W{1'b0}};
            tick_s  = 1'b1;
        end else begin
            presc_s = presc_r + TICK_W'(1);
        end
        if (tick_s) begin
            if ((cifra_zeci == 4'd9) && (cifra_unitati == 4'd9)) begin
                zeci_s    = cifra_zeci;
                unitati_s = cifra_unitati;
            end else if (cifra_unitati >= 4'd9) begin
                unitati_s = 4'd0;
                zeci_s    = cifra_zeci + 4'd1;
            end else begin
                unitati_s = cifra_unitati + 4'd1;
            end
        end else begin
            zeci_s    = cifra_zeci;
            unitati_s = cifra_unitati;
        end
    end

    // State, counters and registered outputs; outputs are derived from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            stare_r        <= MERGE;
            hold_cnt_r     <= {HOLD_W{1'b0}};
            blink_cnt_r    <= {BLINK_W{1'b0}};
            faza_r         <= 1'b0;
            presc_r        <= {TICK_W{1'b0}};
            semnal_stanga  <= 1'b0;
            semnal_dreapta <= 1'b0;
            stop           <= 1'b0;
            cifra_zeci     <= 4'd0;
            cifra_unitati  <= 4'd0;
        end else begin
            stare_r        <= stare_s;
            hold_cnt_r     <= hold_cnt_s;
            blink_cnt_r    <= blink_cnt_s;
            faza_r         <= faza_s;
            presc_r        <= presc_s;
            semnal_stanga  <= (stare_s == VIRAJ_ST) && faza_s;
            semnal_dreapta <= (stare_s == VIRAJ_DR) && faza_s;
            stop           <= (stare_s == OPRIT);
            cifra_zeci     <= zeci_s;
            cifra_unitati  <= unitati_s;
        end
    end

endmodule

// File: tb/tb_comanda_afisaj.sv
// Scoreboard bench for comanda_afisaj with small dividers (TICK 10, BLINK 4, STOP_HOLD 5).
// Stimulus pushes hand-computed expectations tagged with a cycle number; a monitor
// compares them on the falling edge and also checks per-cycle output invariants.
module tb_comanda_afisaj;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ss = 1'b0;
    logic       sc = 1'b1;
    logic       sd = 1'b0;
    logic       semnal_stanga;
    logic       semnal_dreapta;
    logic       stop;
    logic [3:0] cifra_zeci;
    logic [3:0] cifra_unitati;

    typedef struct {
        int         cyc;
        string      name;
        logic       l;
        logic       r;
        logic       s;
        bit         chk_dig;
        logic [3:0] t;
        logic [3:0] u;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   done = 1'b0;

    comanda_afisaj #(
        .TICK_DIV (10),
        .BLINK_DIV(4),
        .STOP_HOLD(5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .senzor_stanga (ss),
        .senzor_centru (sc),
        .senzor_dreapta(sd),
        .semnal_stanga (semnal_stanga),
        .semnal_dreapta(semnal_dreapta),
        .stop          (stop),
        .cifra_zeci    (cifra_zeci),
        .cifra_unitati (cifra_unitati)
    );

    always #5 clock = ~clock;

    // Edge counter used to tag expectations.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_p(input logic [2:0] p);
        {ss, sc, sd} = p;
    endtask

    task automatic push_exp(input string nm, input logic l, input logic r, input logic s,
                            input bit cd, input logic [3:0] t, input logic [3:0] u);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.l = l; e.r = r; e.s = s;
        e.chk_dig = cd; e.t = t; e.u = u;
        sb.push_back(e);
    endtask

    // Monitor: pops expectations due this cycle and checks invariants.
    initial begin
        exp_t e;
        bit ok;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                n_cmp++;
                if ($isunknown({semnal_stanga, semnal_dreapta, stop, cifra_zeci, cifra_unitati}) ||
                    (semnal_stanga && semnal_dreapta) || (cifra_zeci > 4'd9) || (cifra_unitati > 4'd9)) begin
                    n_bad++;
                    $display("FAIL invariant @cyc %0d: got l=%b r=%b t=%0d u=%0d, required no X, not both turns, digits 0..9",
                             cyc, semnal_stanga, semnal_dreapta, cifra_zeci, cifra_unitati);
                end
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                ok = (e.cyc == cyc) && (semnal_stanga === e.l) && (semnal_dreapta === e.r) &&
                     (stop === e.s) &&
                     (!e.chk_dig || ((cifra_zeci === e.t) && (cifra_unitati === e.u)));
                if (!ok) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d (due %0d): got l=%b r=%b s=%b t=%0d u=%0d, required l=%b r=%b s=%b t=%0d u=%0d",
                             e.name, cyc, e.cyc, semnal_stanga, semnal_dreapta, stop, cifra_zeci,
                             cifra_unitati, e.l, e.r, e.s, e.t, e.u);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [14:0] pat_l;
        logic        er;
        logic [3:0]  eu;

        // Reset for 3 cycles, sensors on the straight line.
        set_p(3'b010);
        reset = 1'b1;
        step(); step(); step();
        push_exp("reset", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        mon_en = 1'b1;
        reset  = 1'b0;

        // Seconds count and saturation on 010.
        for (int i = 1; i <= 1100; i++) begin
            step();
            if (i == 9)    push_exp("sec_before_tick", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
            if (i == 10)   push_exp("sec_first_tick",  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1);
            if (i == 99)   push_exp("sec_09",          1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd9);
            if (i == 100)  push_exp("sec_carry_10",    1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0);
            if (i == 989)  push_exp("sec_98",          1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 4'd8);
            if (i == 990)  push_exp("sec_99",          1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 4'd9);
            if (i == 1000) push_exp("sec_sat_a",       1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 4'd9);
            if (i == 1100) push_exp("sec_sat_b",       1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 4'd9);
        end

        // Left turn blink, then back to straight.
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        push_exp("reset2", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        pat_l = 15'b011100001111000;
        set_p(3'b100);
        for (int i = 1; i <= 14; i++) begin
            step();
            push_exp("left_blink", pat_l[i], 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
            if (i == 11) set_p(3'b010);
        end

        // Direct left->right switch, hold patterns while turning right, reset mid-blink.
        set_p(3'b100);
        for (int i = 1; i <= 25; i++) begin
            step();
            er = (i >= 7) && (((i - 7) % 8) < 4);
            push_exp("switch_hold", (i >= 3) && (i <= 6), er, 1'b0, 1'b0, 4'd0, 4'd0);
            if (i == 4)  set_p(3'b001);
            if (i == 15) set_p(3'b000);
            if (i == 17) set_p(3'b101);
            if (i == 21) set_p(3'b001);
        end
        reset = 1'b1;
        set_p(3'b010);
        step();
        push_exp("reset_mid_blink", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        step();
        reset = 1'b0;

        // Stop debounce: 4 cycles of 111 do not stop, 5 do; tick lands on the stopping edge.
        for (int i = 1; i <= 50; i++) begin
            step();
            eu = (i < 10) ? 4'd0 : ((i < 20) ? 4'd1 : 4'd2);
            push_exp("stop_seq", 1'b0, 1'b0, (i >= 20), 1'b1, 4'd0, eu);
            if (i == 2)  set_p(3'b111);
            if (i == 6)  set_p(3'b010);
            if (i == 13) set_p(3'b111);
            if (i == 18) set_p(3'b010);
            if (i == 25) set_p(3'b100);
            if (i == 30) set_p(3'b001);
            if (i == 35) set_p(3'b111);
            if (i == 40) set_p(3'b000);
        end

        // Reset leaves OPRIT.
        reset = 1'b1;
        step();
        push_exp("reset_from_oprit", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        reset = 1'b0;
        step(); step();

        if (sb.size() > 0) begin
            n_cmp += sb.size();
            n_bad += sb.size();
            $display("FAIL scoreboard_drain: got %0d unchecked entries, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
